// File: rtl/conv_pkg.sv
// conv_pkg: pixel/window geometry and FSM state type shared by the 3x3 window generator
package conv_pkg;
    localparam int PIX_W     = 8;
    localparam int WIN_N     = 3;
    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int COL_W     = PIX_W * WIN_N;
    localparam int WIN_W     = COL_W * WIN_N;
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
endpackage

// File: rtl/win_col_shift.sv
// win_col_shift: 3-stage enabled column shift register for both channels of one row source
// ports: clk, rstn (async active-low), en (shift), din_0/din_1 (new column pixel),
//        nxt_0/nxt_1 (register contents after this cycle; [7:0] oldest, [23:16] newest)
module win_col_shift import conv_pkg::*; (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [PIX_W-1:0] din_0,
    input  logic [PIX_W-1:0] din_1,
    output logic [COL_W-1:0] nxt_0,
    output logic [COL_W-1:0] nxt_1
);
    logic [COL_W-1:0] q_0, q_1;
    // nxt is the D input, so the window register can capture the column set that includes this cycle's pixel
    assign nxt_0 = en ? {din_0, q_0[COL_W-1:PIX_W]} : q_0;
    assign nxt_1 = en ? {din_1, q_1[COL_W-1:PIX_W]} : q_1;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_0 <= '0;
            q_1 <= '0;
        end else begin
            q_0 <= nxt_0;
            q_1 <= nxt_1;
        end
    end
endmodule

// File: rtl/window_gen_3x3_dual.sv
// window_gen_3x3_dual: dual-channel 3x3 sliding window generator fed by two external row-buffer taps
// ports: clk, rstn (async active-low), sof/pix_valid (stream control), din_*/row1_*/row2_* (pixel and taps),
//        win_0/win_1 (packed windows, row2 tap at low bits), win_valid, frame_done (pulse), err (sticky)
module window_gen_3x3_dual import conv_pkg::*; #(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sof,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] din_0,
    input  logic [PIX_W-1:0] din_1,
    input  logic [PIX_W-1:0] row1_0,
    input  logic [PIX_W-1:0] row1_1,
    input  logic [PIX_W-1:0] row2_0,
    input  logic [PIX_W-1:0] row2_1,
    output logic [WIN_W-1:0] win_0,
    output logic [WIN_W-1:0] win_1,
    output logic             win_valid,
    output logic             frame_done,
    output logic             err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    state_t state, state_n;
    logic [CW-1:0] col, col_n, cur_col;
    logic [RW-1:0] row, row_n, cur_row;
    logic start, accept, brk, last, wv_n, fd_n, err_n;
    logic [COL_W-1:0] n2_0, n2_1, n1_0, n1_1, nd_0, nd_1;
    assign start   = pix_valid & sof;
    assign accept  = pix_valid & (sof | state != IDLE);
    assign brk     = ~pix_valid & state != IDLE;
    // a sof pixel is position (0,0) regardless of where the counters were
    assign cur_col = start ? '0 : col;
    assign cur_row = start ? '0 : row;
    assign last    = cur_row == ROW_LAST && cur_col == COL_LAST;
    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        wv_n    = 1'b0;
        fd_n    = 1'b0;
        err_n   = err | brk;
        if (brk) begin
            state_n = IDLE;
            col_n   = '0;
            row_n   = '0;
        end else if (accept) begin
            col_n   = cur_col == COL_LAST ? '0 : cur_col + 1'b1;
            row_n   = cur_col != COL_LAST ? cur_row : cur_row == ROW_LAST ? '0 : cur_row + 1'b1;
            wv_n    = cur_row >= RW'(2) && cur_col >= CW'(2);
            fd_n    = state == RUN && !start && last;
            state_n = start ? FILL
                    : (state == FILL && cur_row == RW'(1) && cur_col == COL_LAST) ? RUN
                    : (state == RUN && last) ? IDLE : state;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            win_valid  <= wv_n;
            frame_done <= fd_n;
            err        <= err_n;
        end
    end
    win_col_shift u_row2 (.clk(clk), .rstn(rstn), .en(accept), .din_0(row2_0), .din_1(row2_1), .nxt_0(n2_0), .nxt_1(n2_1));
    win_col_shift u_row1 (.clk(clk), .rstn(rstn), .en(accept), .din_0(row1_0), .din_1(row1_1), .nxt_0(n1_0), .nxt_1(n1_1));
    win_col_shift u_cur  (.clk(clk), .rstn(rstn), .en(accept), .din_0(din_0),  .din_1(din_1),  .nxt_0(nd_0), .nxt_1(nd_1));
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_0 <= '0;
            win_1 <= '0;
        end else if (wv_n) begin
            win_0 <= {nd_0, n1_0, n2_0};
            win_1 <= {nd_1, n1_1, n2_1};
        end
    end
endmodule

// File: tb/tb_window_gen_3x3_dual.sv
// tb_window_gen_3x3_dual: directed checks of window contents, timing, stream breaks, restarts and reset
module tb_window_gen_3x3_dual;
    localparam int W = 8;
    localparam int H = 4;
    logic clk = 1'b0, rstn = 1'b0, sof = 1'b0, pix_valid = 1'b0;
    logic [7:0] din_0 = '0, din_1 = '0, row1_0 = '0, row1_1 = '0, row2_0 = '0, row2_1 = '0;
    logic [71:0] win_0, win_1;
    logic win_valid, frame_done, err;
    int cyc = 0, n_cmp = 0, n_bad = 0, wv_cnt = 0, fd_cnt = 0, first_cyc = -1, sof_cyc = 0;
    logic [71:0] first_w0 = '0, first_w1 = '0, last_w0 = '0;
    logic fd_wv = 1'b0;

    window_gen_3x3_dual #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rstn(rstn), .sof(sof), .pix_valid(pix_valid),
        .din_0(din_0), .din_1(din_1), .row1_0(row1_0), .row1_1(row1_1),
        .row2_0(row2_0), .row2_1(row2_1), .win_0(win_0), .win_1(win_1),
        .win_valid(win_valid), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (win_valid) begin
                wv_cnt++;
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    first_w0  = win_0;
                    first_w1  = win_1;
                end
                last_w0 = win_0;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_wv = win_valid;
            end
        end
    end

    function automatic logic [7:0] pix(int r, int c);
        return r < 0 ? 8'h00 : 8'(r * 16 + c);
    endfunction

    task automatic check(string tag, logic [71:0] got, logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic px(int r, int c, logic v, logic s);
        @(negedge clk);
        pix_valid = v;
        sof       = s;
        din_0     = pix(r, c);
        din_1     = ~din_0;
        row1_0    = pix(r - 1, c);
        row1_1    = ~row1_0;
        row2_0    = pix(r - 2, c);
        row2_1    = ~row2_0;
        if (v && s) sof_cyc = cyc;
    endtask

    task automatic run(int a, int b, logic s);
        for (int i = a; i <= b; i++) px(i / W, i % W, 1'b1, s && i == a);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) px(0, 0, 1'b0, 1'b0);
    endtask

    task automatic clr;
        wv_cnt    = 0;
        fd_cnt    = 0;
        first_cyc = -1;
        fd_wv     = 1'b0;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_wv"},   72'(win_valid),  72'd0);
        check({tag, "_fd"},   72'(frame_done), 72'd0);
        check({tag, "_err"},  72'(err),        72'd0);
        check({tag, "_win0"}, win_0,           72'd0);
        check({tag, "_win1"}, win_1,           72'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("rst");
        rstn = 1'b1;
        idle(2);

        clr;
        run(0, W * H - 1, 1'b1);
        idle(3);
        check("s1_lat",      72'(first_cyc - sof_cyc), 72'd19);
        check("s1_w0_b0",    72'(first_w0[7:0]),   72'h00);
        check("s1_w0_b4",    72'(first_w0[39:32]), 72'h11);
        check("s1_w0_b8",    72'(first_w0[71:64]), 72'h22);
        check("s1_w0_all",   first_w0,             72'h222120121110020100);
        check("s1_w1_b8",    72'(first_w1[71:64]), 72'hDD);
        check("s1_wv_cnt",   72'(wv_cnt),          72'd12);
        check("s1_last_b8",  72'(last_w0[71:64]),  72'h37);
        check("s1_fd_cnt",   72'(fd_cnt),          72'd1);
        check("s1_fd_wv",    72'(fd_wv),           72'd1);
        check("s1_err",      72'(err),             72'd0);

        clr;
        run(0, 2 * W + 3, 1'b1);
        px(2, 4, 1'b0, 1'b0);
        @(negedge clk);
        check("s2_err_next", 72'(err), 72'd1);
        run(2 * W + 5, W * H - 1, 1'b0);
        idle(3);
        check("s2_wv_cnt",   72'(wv_cnt), 72'd2);
        check("s2_fd_cnt",   72'(fd_cnt), 72'd0);
        check("s2_err_hold", 72'(err),    72'd1);

        clr;
        run(0, W + 2, 1'b1);
        run(0, W * H - 1, 1'b1);
        idle(3);
        check("s3_lat",      72'(first_cyc - sof_cyc), 72'd19);
        check("s3_wv_cnt",   72'(wv_cnt),          72'd12);
        check("s3_fd_cnt",   72'(fd_cnt),          72'd1);
        check("s3_last_b8",  72'(last_w0[71:64]),  72'h37);
        check("s3_err",      72'(err),             72'd1);

        clr;
        run(0, 3 * W, 1'b1);
        px(3, 1, 1'b1, 1'b0);
        @(negedge clk);
        rstn      = 1'b0;
        pix_valid = 1'b0;
        #1;
        check_zero("s4_rst");
        @(negedge clk);
        rstn = 1'b1;
        clr;
        run(0, W + 2, 1'b0);
        idle(2);
        check("s4_ignored",  72'(wv_cnt), 72'd0);
        check("s4_ign_err",  72'(err),    72'd0);
        run(0, W * H - 1, 1'b1);
        idle(3);
        check("s4_wv_cnt",   72'(wv_cnt),         72'd12);
        check("s4_fd_cnt",   72'(fd_cnt),         72'd1);
        check("s4_last_b8",  72'(last_w0[71:64]), 72'h37);
        check("s4_err",      72'(err),            72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
